// File: rtl/pgm_mem_pkg.sv
// Shared types and constants for the PGM memory port arbiter.
package pgm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    G_DL,
    G_CPU,
    G_VID
  } grant_t;

  localparam int          PGM_MEM_AW   = 23;
  localparam logic [15:0] PGM_OPEN_BUS = 16'hFFFF;

endpackage

// File: rtl/pgm_mem_arbiter.sv
// Shares one PGM memory port between ioctl download, the 68k and video fetch.
// Download always wins; CPU and video alternate on ties. A watchdog aborts a
// request that is never acknowledged and returns open-bus data.
module pgm_mem_arbiter
  import pgm_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  fixed_20m_clk,
  input  logic                  reset_n,
  input  logic                  dl_wr,
  input  logic [PGM_MEM_AW-1:0] dl_addr,
  input  logic [15:0]           dl_data,
  output logic                  dl_busy,
  output logic                  dl_overflow,
  input  logic                  cpu_sel,
  input  logic                  cpu_as_n,
  input  logic                  cpu_rw_n,
  input  logic                  cpu_uds_n,
  input  logic                  cpu_lds_n,
  input  logic [PGM_MEM_AW-1:0] cpu_addr,
  input  logic [15:0]           cpu_dout,
  output logic [15:0]           cpu_din,
  output logic                  cpu_dtack_n,
  input  logic                  vid_req,
  input  logic [PGM_MEM_AW-1:0] vid_addr,
  output logic [15:0]           vid_rdata,
  output logic                  vid_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [1:0]            mem_be,
  output logic [PGM_MEM_AW-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  timeout_err
);

  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT);

  state_t                state;
  grant_t                grant;
  logic                  last_grant_vid;
  logic [7:0]            wdog;
  logic [PGM_MEM_AW-1:0] dl_addr_q;
  logic [15:0]           dl_data_q;
  logic                  cpu_done;

  logic                  cpu_pend;
  logic                  dl_pend;
  logic                  cpu_wins;
  logic                  timeout_hit;
  logic                  finish;
  logic                  dl_release;
  logic [15:0]           result;
  logic [PGM_MEM_AW-1:0] dl_src_addr;
  logic [15:0]           dl_src_data;

  assign cpu_pend    = !cpu_as_n && cpu_sel && !cpu_done;
  // A write strobe seen in IDLE is served at once, even before the buffer flag is visible.
  assign dl_pend     = dl_busy || dl_wr;
  assign dl_src_addr = dl_busy ? dl_addr_q : dl_addr;
  assign dl_src_data = dl_busy ? dl_data_q : dl_data;
  // CPU wins a tie only when video was granted last.
  assign cpu_wins    = cpu_pend && (!vid_req || last_grant_vid);
  // A real acknowledge in the final watchdog cycle takes precedence over the abort.
  assign timeout_hit = (state == REQ) && !mem_ack && ((wdog + 8'd1) == WDOG_LIMIT);
  assign finish      = (state == REQ) && (mem_ack || timeout_hit);
  assign dl_release  = finish && (grant == G_DL);
  assign result      = mem_ack ? mem_rdata : PGM_OPEN_BUS;

  // Arbitration FSM: grant, drive the memory port, and register the delivered result.
  always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      grant          <= G_DL;
      last_grant_vid <= 1'b1;
      wdog           <= 8'd0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_be         <= 2'b00;
      mem_addr       <= '0;
      mem_wdata      <= 16'h0000;
      vid_rdata      <= 16'h0000;
      vid_ack        <= 1'b0;
      cpu_din        <= PGM_OPEN_BUS;
      timeout_err    <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= 8'd0;
          if (dl_pend) begin
            grant     <= G_DL;
            mem_addr  <= dl_src_addr;
            mem_wdata <= dl_src_data;
            mem_we    <= 1'b1;
            mem_be    <= 2'b11;
            mem_req   <= 1'b1;
            state     <= REQ;
          end else if (cpu_wins) begin
            grant          <= G_CPU;
            last_grant_vid <= 1'b0;
            mem_addr       <= cpu_addr;
            mem_wdata      <= cpu_dout;
            mem_we         <= !cpu_rw_n;
            mem_be         <= ~{cpu_uds_n, cpu_lds_n};
            mem_req        <= 1'b1;
            state          <= REQ;
          end else if (vid_req) begin
            grant          <= G_VID;
            last_grant_vid <= 1'b1;
            mem_addr       <= vid_addr;
            mem_we         <= 1'b0;
            mem_be         <= 2'b11;
            mem_req        <= 1'b1;
            state          <= REQ;
          end
        end
        REQ: begin
          if (finish) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (timeout_hit) timeout_err <= 1'b1;
            if (grant == G_VID) begin
              vid_ack   <= 1'b1;
              vid_rdata <= result;
            end
            if (grant == G_CPU) cpu_din <= result;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry download buffer with sticky overflow on a write that finds it full.
  always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_busy     <= 1'b0;
      dl_overflow <= 1'b0;
      dl_addr_q   <= '0;
      dl_data_q   <= 16'h0000;
    end else if (dl_wr && (!dl_busy || dl_release)) begin
      dl_busy   <= 1'b1;
      dl_addr_q <= dl_addr;
      dl_data_q <= dl_data;
    end else if (dl_wr) begin
      dl_overflow <= 1'b1;
    end else if (dl_release) begin
      dl_busy <= 1'b0;
    end
  end

  // Marks the current 68k bus cycle as served until address strobe is released.
  always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_done <= 1'b0;
    end else if (cpu_as_n) begin
      cpu_done <= 1'b0;
    end else if (finish && (grant == G_CPU)) begin
      cpu_done <= 1'b1;
    end
  end

  // DTACK asserts with the result and holds until the 68k releases address strobe.
  always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dtack_n <= 1'b1;
    end else if (finish && (grant == G_CPU) && !cpu_as_n) begin
      cpu_dtack_n <= 1'b0;
    end else if (cpu_as_n) begin
      cpu_dtack_n <= 1'b1;
    end
  end

endmodule
